// File: rtl/fft_stage_controller_if.sv
// Bus bundle between the FFT stage controller, the frame source/sink,
// the MAC_Array butterfly lanes and the twiddle ROM.
interface fft_stage_controller_if;
    logic         Start;
    logic [511:0] Data_In;
    logic         Busy;
    logic [2:0]   Stage;
    logic [255:0] Twiddle_In;
    logic [511:0] MAC_In1_2;
    logic [255:0] MAC_In3;
    logic [511:0] MAC_Out1_2;
    logic         MAC_Overflow;
    logic [511:0] Data_Out;
    logic         Out_Valid;
    logic         Out_Ready;
    logic         Overflow;

    modport master (
        input  Start, Data_In, Twiddle_In, MAC_Out1_2, MAC_Overflow, Out_Ready,
        output Busy, Stage, MAC_In1_2, MAC_In3, Data_Out, Out_Valid, Overflow
    );

    modport slave (
        output Start, Data_In, Twiddle_In, MAC_Out1_2, MAC_Overflow, Out_Ready,
        input  Busy, Stage, MAC_In1_2, MAC_In3, Data_Out, Out_Valid, Overflow
    );
endinterface

// File: rtl/fft_stage_controller.sv
// Sequences a 32-point frame through NUM_STAGES constant-geometry butterfly
// passes on the 16-lane MAC_Array, one stage per clock, then hands it off.
module fft_stage_controller #(
    parameter int NUM_STAGES = 5
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    fft_stage_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    state_t      state_reg;
    logic        busy_reg;
    logic        out_valid_reg;
    logic        overflow_reg;
    logic [2:0]  stage_reg;
    logic [15:0] buf_reg [32];

    logic [15:0] din_word [32];
    logic [15:0] wb_word  [32];
    logic        compute_active;
    logic        load_frame;

    assign compute_active = (state_reg == COMPUTE);
    // A new frame is accepted from IDLE, or from OUTPUT only when the
    // current frame leaves in the same cycle.
    assign load_frame = bus.Start &&
                        ((state_reg == IDLE) ||
                         ((state_reg == OUTPUT) && bus.Out_Ready));

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sample
            assign din_word[gi] = bus.Data_In[16*gi +: 16];
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign wb_word[2*gi]     = bus.MAC_Out1_2[32*gi      +: 16];
            assign wb_word[2*gi + 1] = bus.MAC_Out1_2[32*gi + 16 +: 16];
        end
    endgenerate

    always_comb begin
        bus.MAC_In1_2 = '0;
        bus.MAC_In3   = '0;
        bus.Data_Out  = '0;
        for (int k = 0; k < 16; k++) begin
            if (compute_active) begin
                bus.MAC_In1_2[32*k +: 32] = {buf_reg[k + 16], buf_reg[k]};
                bus.MAC_In3[16*k +: 16]   = bus.Twiddle_In[16*k +: 16];
            end
        end
        for (int i = 0; i < 32; i++) begin
            bus.Data_Out[16*i +: 16] = buf_reg[i];
        end
    end

    assign bus.Busy      = busy_reg;
    assign bus.Stage     = stage_reg;
    assign bus.Out_Valid = out_valid_reg;
    assign bus.Overflow  = overflow_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            stage_reg     <= 3'd0;
            for (int i = 0; i < 32; i++) begin
                buf_reg[i] <= 16'd0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_frame) begin
                        for (int i = 0; i < 32; i++) begin
                            buf_reg[i] <= din_word[i];
                        end
                        overflow_reg <= 1'b0;
                        stage_reg    <= 3'd0;
                        busy_reg     <= 1'b1;
                        state_reg    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int i = 0; i < 32; i++) begin
                        buf_reg[i] <= wb_word[i];
                    end
                    overflow_reg <= overflow_reg | bus.MAC_Overflow;
                    if (stage_reg == LAST_STAGE) begin
                        stage_reg     <= 3'd0;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUTPUT;
                    end else begin
                        stage_reg <= stage_reg + 3'd1;
                    end
                end
                OUTPUT: begin
                    if (bus.Out_Ready) begin
                        out_valid_reg <= 1'b0;
                        if (load_frame) begin
                            for (int i = 0; i < 32; i++) begin
                                buf_reg[i] <= din_word[i];
                            end
                            overflow_reg <= 1'b0;
                            stage_reg    <= 3'd0;
                            busy_reg     <= 1'b1;
                            state_reg    <= COMPUTE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
